// File: rtl/nes_target.sv
// nes_target: I2C target emulating an NES Classic / Wii extension controller.
// A one-byte pointer write selects a register. Reads return a 6-byte report.
// Bytes 4 and 5 of the report carry the joypad vector.
// Optional build macro: NES_TARGET_ACTIVE_LOW_EN. When defined, report bytes 4/5
// are bitwise inverted, so pressed = 0 and unmapped bits = 1.
module nes_target #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h52,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] joypad,
  output logic       busy,
  output logic       report_done
);

  // Joypad bit indices; same values as the JOYP_* defines in nes_bridge.vh.
  localparam int JOYP_A      = 0;
  localparam int JOYP_B      = 1;
  localparam int JOYP_SELECT = 2;
  localparam int JOYP_START  = 3;
  localparam int JOYP_UP     = 4;
  localparam int JOYP_DOWN   = 5;
  localparam int JOYP_LEFT   = 6;
  localparam int JOYP_RIGHT  = 7;

  // A synchronizer with fewer than two flops is not safe, so the depth is clamped to 2.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

`ifdef NES_TARGET_ACTIVE_LOW_EN
  localparam logic [7:0] PAD_XOR = 8'hFF;
`else
  localparam logic [7:0] PAD_XOR = 8'h00;
`endif

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  state_t state, state_n;

  logic [SYNC_N-1:0] scl_sync, sda_sync;
  logic              scl_d, sda_d;
  logic              scl_s, sda_s;
  logic              scl_rise, scl_fall, start_det, stop_det;

  logic [3:0] bit_cnt, bit_cnt_n;
  logic [6:0] rx, rx_n;
  logic [7:0] tx, tx_n;
  logic [7:0] ptr, ptr_n;
  logic [7:0] snap, snap_n;
  logic [7:0] first_byte, next_byte;
  logic       rw, rw_n;
  logic       ptr_load, ptr_load_n;
  logic       nack, nack_n;
  logic       sda_n, busy_n, done_n;

  // Report register map: bytes 0-3 are zero, 4/5 hold buttons, 6+ read as FF.
  function automatic logic [7:0] report_byte(input logic [7:0] p, input logic [7:0] pad);
    logic [7:0] b;
    b = 8'h00;
    case (p)
      8'd4: b = {pad[JOYP_RIGHT], pad[JOYP_DOWN], 1'b0, pad[JOYP_SELECT],
                 1'b0, pad[JOYP_START], 2'b00} ^ PAD_XOR;
      8'd5: b = {1'b0, pad[JOYP_B], 1'b0, pad[JOYP_A],
                 2'b00, pad[JOYP_LEFT], pad[JOYP_UP]} ^ PAD_XOR;
      default: b = (p >= 8'd6) ? 8'hFF : 8'h00;
    endcase
    return b;
  endfunction

  assign scl_s     = scl_sync[SYNC_N-1];
  assign sda_s     = sda_sync[SYNC_N-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  // The first byte of a read uses live joypad, which is snapshotted in the same cycle.
  // Later bytes come from that snapshot.
  assign first_byte = report_byte(ptr, joypad);
  assign next_byte  = report_byte(ptr, snap);

  // Bus synchronizers plus one delay stage for edge detection; the idle bus level is high.
  // NOTE: sequential logic uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_N-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_N-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // State and datapath registers; reset releases SDA immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      rx          <= 7'd0;
      tx          <= 8'd0;
      ptr         <= 8'd0;
      snap        <= 8'd0;
      rw          <= 1'b0;
      ptr_load    <= 1'b0;
      nack        <= 1'b0;
      sda_out     <= 1'b1;
      busy        <= 1'b0;
      report_done <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      rx          <= rx_n;
      tx          <= tx_n;
      ptr         <= ptr_n;
      snap        <= snap_n;
      rw          <= rw_n;
      ptr_load    <= ptr_load_n;
      nack        <= nack_n;
      sda_out     <= sda_n;
      busy        <= busy_n;
      report_done <= done_n;
    end
  end

  // Protocol FSM: START/STOP override everything; bits are sampled on SCL rise, driven on SCL fall.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    rx_n       = rx;
    tx_n       = tx;
    ptr_n      = ptr;
    snap_n     = snap;
    rw_n       = rw;
    ptr_load_n = ptr_load;
    nack_n     = nack;
    sda_n      = sda_out;
    busy_n     = busy;
    done_n     = 1'b0;

    if (stop_det) begin
      state_n = IDLE;
      sda_n   = 1'b1;
      busy_n  = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 4'd0;
      sda_n     = 1'b1;
    end else begin
      case (state)
        IDLE: ;

        ADDR: if (scl_rise) begin
          rx_n      = {rx[5:0], sda_s};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = 4'd0;
            if (rx == SLAVE_ADDR) begin
              state_n = ADDR_ACK;
              busy_n  = 1'b1;
              rw_n    = sda_s;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
        end

        // bit_cnt 0: waiting for the 8th fall to assert ACK; 1: waiting for the 9th fall.
        ADDR_ACK: if (scl_fall) begin
          if (bit_cnt == 4'd0) begin
            sda_n     = 1'b0;
            bit_cnt_n = 4'd1;
          end else if (rw) begin
            snap_n    = joypad;
            sda_n     = first_byte[7];
            tx_n      = {first_byte[6:0], 1'b0};
            bit_cnt_n = 4'd1;
            state_n   = RD_DATA;
          end else begin
            sda_n      = 1'b1;
            bit_cnt_n  = 4'd0;
            ptr_load_n = 1'b1;
            state_n    = WR_DATA;
          end
        end

        WR_DATA: if (scl_rise) begin
          rx_n      = {rx[5:0], sda_s};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = 4'd0;
            state_n   = WR_ACK;
            if (ptr_load) begin
              ptr_n      = {rx, sda_s};
              ptr_load_n = 1'b0;
            end
          end
        end

        WR_ACK: if (scl_fall) begin
          if (bit_cnt == 4'd0) begin
            sda_n     = 1'b0;
            bit_cnt_n = 4'd1;
          end else begin
            sda_n     = 1'b1;
            bit_cnt_n = 4'd0;
            state_n   = WR_DATA;
          end
        end

        // bit_cnt counts bits already placed on the bus; bit7 went out on entry.
        RD_DATA: if (scl_fall) begin
          if (bit_cnt == 4'd8) begin
            sda_n     = 1'b1;
            bit_cnt_n = 4'd0;
            state_n   = RD_ACK;
          end else begin
            sda_n     = tx[7];
            tx_n      = {tx[6:0], 1'b0};
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            nack_n    = sda_s;
            bit_cnt_n = 4'd1;
            done_n    = (ptr == 8'd5);
            if (ptr != 8'hFF) ptr_n = ptr + 8'd1;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            bit_cnt_n = 4'd0;
            if (nack) begin
              state_n = IDLE;
            end else begin
              sda_n     = next_byte[7];
              tx_n      = {next_byte[6:0], 1'b0};
              bit_cnt_n = 4'd1;
              state_n   = RD_DATA;
            end
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

endmodule
